// File: rtl/fix_inv_sqrt_nr.sv
// rtl/fix_inv_sqrt_nr.sv - fixed-point Newton-Raphson inverse square root refinement (optional sat_flag port: INV_SQRT_SAT_FLAG_EN)
module fix_inv_sqrt_nr #(
  parameter int INT_WIDTH   = 4,
  parameter int FRACT_WIDTH = 12,
  parameter int ITERATIONS  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] x_fix,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] y0_fix,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0] y_fix
`ifdef INV_SQRT_SAT_FLAG_EN
  ,
  output logic                             sat_flag
`endif
);

  localparam int W = INT_WIDTH + FRACT_WIDTH;
  localparam logic [W-1:0] THREE = W'(3 * (1 << FRACT_WIDTH));
  localparam logic [W-1:0] ONES  = '1;
  localparam logic [2:0]   LAST_ITER = 3'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    IDLE,
    MUL_YY,
    MUL_XT,
    SUB,
    MUL_YT,
    OUT
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   t_q, t_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           ev_q, ev_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   y_fix_q, y_fix_d;
`ifdef INV_SQRT_SAT_FLAG_EN
  logic           sat_flag_q, sat_flag_d;
`endif

  logic [W-1:0]   mul_a, mul_b;
  logic           mul_shr1;
  logic [2*W-1:0] mul_prod, mul_shift;
  logic           mul_ovf;
  logic [W-1:0]   mul_res;

  // Shared multiplier: operand select per state, truncating shift, saturate on overflow
  always_comb begin
    mul_a    = y_q;
    mul_b    = y_q;
    mul_shr1 = 1'b0;
    case (state_q)
      MUL_XT: begin
        mul_a = x_q;
        mul_b = t_q;
      end
      MUL_YT: begin
        mul_a    = y_q;
        mul_b    = t_q;
        mul_shr1 = 1'b1;
      end
      default: ;
    endcase
    mul_prod  = (2*W)'(mul_a) * (2*W)'(mul_b);
    mul_shift = mul_shr1 ? (mul_prod >> (FRACT_WIDTH + 1)) : (mul_prod >> FRACT_WIDTH);
    mul_ovf   = |mul_shift[2*W-1:W];
    mul_res   = mul_ovf ? ONES : mul_shift[W-1:0];
  end

  // Next-state and datapath updates, one step of y*(3 - x*y*y)/2 per cycle
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    t_d         = t_q;
    cnt_d       = cnt_q;
    ev_d        = ev_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    y_fix_d     = y_fix_q;
`ifdef INV_SQRT_SAT_FLAG_EN
    sat_flag_d  = sat_flag_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = x_fix;
          y_d        = y0_fix;
          cnt_d      = 3'd0;
          ev_d       = 1'b0;
          in_ready_d = 1'b0;
          state_d    = MUL_YY;
`ifdef INV_SQRT_SAT_FLAG_EN
          sat_flag_d = 1'b0;
`endif
        end
      end
      MUL_YY: begin
        t_d     = mul_res;
        ev_d    = ev_q | mul_ovf;
        state_d = MUL_XT;
      end
      MUL_XT: begin
        t_d     = mul_res;
        ev_d    = ev_q | mul_ovf;
        state_d = SUB;
      end
      SUB: begin
        // A product above 3.0 would make the correction negative; clamp it to zero
        if (t_q > THREE) begin
          t_d  = '0;
          ev_d = 1'b1;
        end else begin
          t_d = THREE - t_q;
        end
        state_d = MUL_YT;
      end
      MUL_YT: begin
        y_d   = mul_res;
        ev_d  = ev_q | mul_ovf;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_ITER) begin
          // x == 0 has no finite inverse root: report full scale
          y_fix_d     = (x_q == '0) ? ONES : mul_res;
          out_valid_d = 1'b1;
          state_d     = OUT;
`ifdef INV_SQRT_SAT_FLAG_EN
          sat_flag_d  = ev_q | mul_ovf | (x_q == '0);
`endif
        end else begin
          state_d = MUL_YY;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      t_q         <= '0;
      cnt_q       <= 3'd0;
      ev_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_fix_q     <= '0;
`ifdef INV_SQRT_SAT_FLAG_EN
      sat_flag_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      ev_q        <= ev_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_fix_q     <= y_fix_d;
`ifdef INV_SQRT_SAT_FLAG_EN
      sat_flag_q  <= sat_flag_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y_fix     = y_fix_q;
`ifdef INV_SQRT_SAT_FLAG_EN
  assign sat_flag  = sat_flag_q;
`endif

endmodule

// File: tb/tb_fix_inv_sqrt_nr.sv
// tb/tb_fix_inv_sqrt_nr.sv - self-checking bench for fix_inv_sqrt_nr
module tb_fix_inv_sqrt_nr;

  localparam int F     = 12;
  localparam int ITER  = 2;
  localparam int LAT   = 4 * ITER;
  localparam longint ONES  = 65535;
  localparam longint THREE = 3 * 4096;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_fix;
  logic [15:0] y0_fix;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y_fix;
`ifdef INV_SQRT_SAT_FLAG_EN
  logic        sat_flag;
`endif

  int tests;
  int failed;

  fix_inv_sqrt_nr #(
    .INT_WIDTH  (4),
    .FRACT_WIDTH(F),
    .ITERATIONS (ITER)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_fix    (x_fix),
    .y0_fix   (y0_fix),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y_fix    (y_fix)
`ifdef INV_SQRT_SAT_FLAG_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y0;
    logic [15:0] exp_y;
    logic        exp_sat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: Newton-Raphson on plain integers with saturation/clamp rules
  function automatic longint sat16(input longint v, inout bit s);
    if (v > ONES) begin
      s = 1'b1;
      return ONES;
    end
    return v;
  endfunction

  function automatic void model(input longint x, input longint y0,
                                output longint y, output bit s);
    longint t;
    s = 1'b0;
    y = y0;
    for (int i = 0; i < ITER; i++) begin
      t = sat16((y * y) >> F, s);
      t = sat16((x * t) >> F, s);
      if (t > THREE) begin
        t = 0;
        s = 1'b1;
      end else begin
        t = THREE - t;
      end
      y = sat16((y * t) >> (F + 1), s);
    end
    if (x == 0) begin
      y = ONES;
      s = 1'b1;
    end
  endfunction

  task automatic start_op(input logic [15:0] x, input logic [15:0] y0);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    x_fix    = x;
    y0_fix   = y0;
    @(negedge clk);
    in_valid = 1'b0;
    x_fix    = 16'($urandom);
    y0_fix   = 16'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [15:0] x, input logic [15:0] y0,
                           input logic [15:0] exp_y, input logic exp_sat);
    int lat;
    start_op(x, y0);
    wait_out(lat);
    check({name, "_latency"}, lat, LAT);
    check({name, "_y"}, y_fix, exp_y);
`ifdef INV_SQRT_SAT_FLAG_EN
    check({name, "_sat"}, sat_flag, exp_sat);
`else
    if (exp_sat) ;
`endif
    release_out();
  endtask

  initial begin
    vec_t   tbl[5];
    longint my;
    bit     ms;
    int     lat;
    logic [15:0] hold_y;

    tests     = 0;
    failed    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_fix     = '0;
    y0_fix    = '0;

    tbl[0] = '{16'd4096,  16'd4096, 16'd4096,  1'b0};
    tbl[1] = '{16'd16384, 16'd2048, 16'd2048,  1'b0};
    tbl[2] = '{16'd4096,  16'd3072, 16'd4052,  1'b0};
    tbl[3] = '{16'd61440, 16'd4096, 16'd0,     1'b1};
    tbl[4] = '{16'd0,     16'd4096, 16'd65535, 1'b1};

    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_y_fix", y_fix, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_check($sformatf("vec%0d", i), tbl[i].x, tbl[i].y0, tbl[i].exp_y, tbl[i].exp_sat);
    end

    // Backpressure: result must hold while out_ready is low
    start_op(16'd4096, 16'd3072);
    wait_out(lat);
    check("hold_latency", lat, LAT);
    hold_y = y_fix;
    check("hold_y_first", hold_y, 4052);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_y_stable", y_fix, hold_y);
      check("hold_in_ready", in_ready, 0);
    end
    release_out();
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    run_check("after_hold", 16'd16384, 16'd2048, 16'd2048, 1'b0);

    // Reset during MUL_XT aborts the operation
    start_op(16'd4096, 16'd3072);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_check("post_reset", 16'd4096, 16'd4096, 16'd4096, 1'b0);

    // Randomized operands against the reference model
    for (int i = 0; i < 25; i++) begin
      logic [15:0] rx, ry;
      case (i % 3)
        0: begin rx = 16'($urandom);                 ry = 16'($urandom); end
        1: begin rx = 16'($urandom_range(1024, 32768)); ry = 16'($urandom_range(1024, 8192)); end
        default: begin rx = 16'($urandom_range(0, 8)); ry = 16'($urandom_range(0, 65535)); end
      endcase
      model(longint'(rx), longint'(ry), my, ms);
      run_check($sformatf("rand%0d", i), rx, ry, 16'(my), ms);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
